fetch_stage: RTL

Instruction fetch stage of the RV32I core, directly upstream of the instruction decoder. It owns the program counter, issues word reads to instruction memory over a request/grant/response interface, and presents each returned 32-bit instruction word with its PC to decode through a valid/ready handshake. It also accepts a PC redirect from execute (branch/jump) and flushes any in-flight or held fetch.

---
 rtl/fetch_stage.sv | 85 ++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, issues one outstanding word read to
// instruction memory and hands each returned word with its PC to decode.
module fetch_stage #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_gnt,
  input  logic             i_imem_rvalid,
  input  logic [WIDTH-1:0] i_imem_rdata,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic [WIDTH-1:0] o_instruction,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_valid,
  input  logic             i_ready
);

  typedef enum logic {FETCH, WAIT} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] pc_reg;
  logic             discard_reg;
  logic [WIDTH-1:0] instr_reg;
  logic [WIDTH-1:0] out_pc_reg;
  logic             valid_reg;

  // Reset gates the request so memory never sees one while reset is held.
  assign o_imem_req    = i_rst_n && (state_reg == FETCH) && (!valid_reg || i_ready) && !i_redirect;
  assign o_imem_addr   = {pc_reg[WIDTH-1:2], 2'b00};
  assign o_instruction = instr_reg;
  assign o_pc          = out_pc_reg;
  assign o_valid       = valid_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      discard_reg <= 1'b0;
      instr_reg   <= '0;
      out_pc_reg  <= '0;
      valid_reg   <= 1'b0;
    end else if (i_redirect) begin
      pc_reg    <= {i_redirect_pc[WIDTH-1:2], 2'b00};
      valid_reg <= 1'b0;
      if (state_reg == WAIT) begin
        // A response still in flight must be swallowed when it finally arrives.
        if (i_imem_rvalid) begin
          state_reg   <= FETCH;
          discard_reg <= 1'b0;
        end else begin
          discard_reg <= 1'b1;
        end
      end
    end else begin
      if (valid_reg && i_ready)
        valid_reg <= 1'b0;
      case (state_reg)
        FETCH: begin
          if (o_imem_req && i_imem_gnt) begin
            state_reg   <= WAIT;
            discard_reg <= 1'b0;
          end
        end
        WAIT: begin
          if (i_imem_rvalid) begin
            if (!discard_reg) begin
              instr_reg  <= i_imem_rdata;
              out_pc_reg <= pc_reg;
              valid_reg  <= 1'b1;
              pc_reg     <= pc_reg + WIDTH'(4);
            end
            state_reg   <= FETCH;
            discard_reg <= 1'b0;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule
